fx68k_rom_stream_reader: RTL

//  Burst reader in front of the micro/nano ROM (fx68kRom). Issues sequential ROM addresses
//  and absorbs the 1- or 2-cycle ROM read latency. Buffers returned words in a small FIFO.

---
 rtl/fx68k_rom_stream_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/fx68k_rom_stream_reader.sv
// Burst reader for the fx68k micro/nano ROM: issues sequential addresses, tracks the
// 1-2 cycle ROM latency with a valid shift pipe and buffers words for a valid/ready stream.
module fx68k_rom_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_REG = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_clk_ena,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int LAT = 1 + OUTPUT_REG;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  issue_rem, out_rem;
  logic [LAT-1:0]        vld_pipe;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count, inflight;
  logic                  fire, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Credits cover both buffered and in-flight words, so a returning read always has a slot.
  assign fire      = (state == ISSUE) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
  assign push      = vld_pipe[LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (out_rem == LEN_WIDTH'(1));
  assign busy      = (state != IDLE);
  assign rom_addr  = addr_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rom_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      issue_rem   <= '0;
      out_rem     <= '0;
      vld_pipe    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rom_clk_ena <= 1'b0;
    end else begin
      rom_clk_ena <= 1'b1;
      if (abort) begin
        // Data still coming back from the ROM is dropped by clearing the pipe.
        state      <= IDLE;
        vld_pipe   <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        vld_pipe   <= (vld_pipe << 1) | LAT'(fire);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          out_rem <= out_rem - LEN_WIDTH'(1);
        end
        case (state)
          IDLE: if (start && burst_len != '0) begin
            addr_cnt  <= start_addr;
            issue_rem <= burst_len;
            out_rem   <= burst_len;
            state     <= ISSUE;
          end
          ISSUE: if (fire) begin
            addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
            issue_rem <= issue_rem - LEN_WIDTH'(1);
            if (issue_rem == LEN_WIDTH'(1)) state <= DRAIN;
          end
          DRAIN: if (pop && out_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || abort)
    !(push && fifo_count == CW'(FIFO_DEPTH)));

endmodule
